// File: rtl/clink_pkg.sv
// Camera Link Base definitions shared by the X-channel transmit framer and receiver:
// pixel/strobe bundle, TxIN bit map, and pack/unpack helpers that are exact inverses.
package clink_pkg;

    typedef struct packed {
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] d2;
        logic       lval;
        logic       fval;
        logic       dval;
    } clink_base_t;

    localparam int TXIN_W   = 28;
    localparam int TX_SPARE = 23;
    localparam int TX_LVAL  = 24;
    localparam int TX_FVAL  = 25;
    localparam int TX_DVAL  = 26;

    // TxIN bit position of each data bit, indexed by data bit number 0..7
    localparam int D0_IDX [8] = '{0, 1, 2, 3, 4, 6, 27, 5};
    localparam int D1_IDX [8] = '{7, 8, 9, 12, 13, 14, 10, 11};
    localparam int D2_IDX [8] = '{15, 18, 19, 20, 21, 22, 16, 17};

    function automatic logic [TXIN_W-1:0] pack_txin(input clink_base_t b);
        logic [TXIN_W-1:0] t;
        t = '0;
        for (int i = 0; i < 8; i++) begin
            t[D0_IDX[i]] = b.d0[i];
            t[D1_IDX[i]] = b.d1[i];
            t[D2_IDX[i]] = b.d2[i];
        end
        t[TX_LVAL] = b.lval;
        t[TX_FVAL] = b.fval;
        t[TX_DVAL] = b.dval;
        return t;
    endfunction

    function automatic clink_base_t unpack_txin(input logic [TXIN_W-1:0] t);
        clink_base_t b;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            b.d0[i] = t[D0_IDX[i]];
            b.d1[i] = t[D1_IDX[i]];
            b.d2[i] = t[D2_IDX[i]];
        end
        b.lval = t[TX_LVAL];
        b.fval = t[TX_FVAL];
        b.dval = t[TX_DVAL];
        return b;
    endfunction

endpackage

// File: rtl/clink_base_tx_framer.sv
// Camera Link Base transmit framer: on a trigger edge emits one frame of FVAL/LVAL/DVAL timing
// with 3 pixels per word (stream or test pattern), packed into a registered 28-bit TxIN word.
module clink_base_tx_framer
    import clink_pkg::*;
#(
    parameter int H_W   = 12,
    parameter int V_W   = 12,
    parameter int CNT_W = 16
) (
    input  logic             clink_X_clk,
    input  logic             reset,
    input  logic             trigger,
    input  logic             cfg_test_pattern,
    input  logic [H_W-1:0]   cfg_h_words,
    input  logic [H_W-1:0]   cfg_h_blank,
    input  logic [V_W-1:0]   cfg_v_lines,
    input  logic [7:0]       cfg_fv_setup,
    input  logic [23:0]      s_pix_tdata,
    input  logic             s_pix_tvalid,
    output logic             s_pix_tready,
    output logic [27:0]      tx_word,
    output logic             busy,
    output logic             image_end,
    output logic             trig_overrun,
    output logic [CNT_W-1:0] frame_count
);

    localparam int CW = (H_W > 8) ? H_W : 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRE    = 3'd1;
    localparam logic [2:0] ST_ACTIVE = 3'd2;
    localparam logic [2:0] ST_BLANK  = 3'd3;
    localparam logic [2:0] ST_POST   = 3'd4;

    logic [2:0]       state_reg, state_next, ph;
    logic [CW-1:0]    cnt_reg, cnt_next, cnt_cur;
    logic [H_W-1:0]   word_reg, word_next, word_cur;
    logic [V_W-1:0]   line_reg, line_next, line_cur;
    logic             pat_reg, cur_pat;
    logic [H_W-1:0]   h_words_reg, h_blank_reg, cur_h_words, cur_h_blank;
    logic [V_W-1:0]   v_lines_reg, cur_v_lines;
    logic [7:0]       fv_setup_reg, cur_fv_setup;
    logic             trigger_q_reg;
    logic [27:0]      tx_word_reg;
    logic             busy_reg, image_end_reg, overrun_reg, end_next;
    logic [CNT_W-1:0] frame_count_reg;
    logic             start, idle_free, cfg_ok, go, fire;
    clink_base_t      emit;
    logic [7:0]       pat_byte [3];

    assign start     = trigger & ~trigger_q_reg;
    // The cycle after the last FVAL word and the image_end cycle both still belong to the old frame
    assign idle_free = (state_reg == ST_IDLE) && !busy_reg && !image_end_reg;
    assign cfg_ok    = (cfg_h_words != '0) && (cfg_v_lines != '0);
    assign go        = start && idle_free && cfg_ok;

    // On the start cycle the first frame word is produced directly from the live config
    assign cur_pat      = go ? cfg_test_pattern : pat_reg;
    assign cur_h_words  = go ? cfg_h_words      : h_words_reg;
    assign cur_h_blank  = go ? cfg_h_blank      : h_blank_reg;
    assign cur_v_lines  = go ? cfg_v_lines      : v_lines_reg;
    assign cur_fv_setup = go ? cfg_fv_setup     : fv_setup_reg;
    assign cnt_cur      = go ? '0 : cnt_reg;
    assign word_cur     = go ? '0 : word_reg;
    assign line_cur     = go ? '0 : line_reg;
    assign ph           = go ? ((cfg_fv_setup != 8'd0) ? ST_PRE : ST_ACTIVE) : state_reg;

    assign s_pix_tready = (ph == ST_ACTIVE) && !cur_pat;
    assign fire         = cur_pat | s_pix_tvalid;
    assign end_next     = busy_reg && (state_reg == ST_IDLE);

    for (genvar gi = 0; gi < 3; gi++) begin : g_pat
        assign pat_byte[gi] = 8'(word_cur) * 8'd3 + 8'(gi) + 8'(line_cur);
    end

    always_comb begin
        state_next = ph;
        cnt_next   = cnt_cur;
        word_next  = word_cur;
        line_next  = line_cur;
        emit       = '0;
        case (ph)
            ST_PRE, ST_POST: begin
                emit.fval = 1'b1;
                if (cnt_cur + CW'(1) == CW'(cur_fv_setup)) begin
                    cnt_next   = '0;
                    state_next = (ph == ST_PRE) ? ST_ACTIVE : ST_IDLE;
                end else begin
                    cnt_next = cnt_cur + CW'(1);
                end
            end
            ST_BLANK: begin
                emit.fval = 1'b1;
                if (cnt_cur + CW'(1) == CW'(cur_h_blank)) begin
                    cnt_next   = '0;
                    state_next = ST_ACTIVE;
                end else begin
                    cnt_next = cnt_cur + CW'(1);
                end
            end
            ST_ACTIVE: begin
                emit.fval = 1'b1;
                emit.lval = 1'b1;
                if (fire) begin
                    emit.dval = 1'b1;
                    emit.d0   = cur_pat ? pat_byte[0] : s_pix_tdata[7:0];
                    emit.d1   = cur_pat ? pat_byte[1] : s_pix_tdata[15:8];
                    emit.d2   = cur_pat ? pat_byte[2] : s_pix_tdata[23:16];
                    if (word_cur == cur_h_words - H_W'(1)) begin
                        word_next = '0;
                        if (line_cur == cur_v_lines - V_W'(1)) begin
                            line_next  = '0;
                            state_next = (cur_fv_setup == 8'd0) ? ST_IDLE : ST_POST;
                        end else begin
                            line_next  = line_cur + V_W'(1);
                            state_next = (cur_h_blank == '0) ? ST_ACTIVE : ST_BLANK;
                        end
                    end else begin
                        word_next = word_cur + H_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clink_X_clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            word_reg        <= '0;
            line_reg        <= '0;
            pat_reg         <= 1'b0;
            h_words_reg     <= '0;
            h_blank_reg     <= '0;
            v_lines_reg     <= '0;
            fv_setup_reg    <= '0;
            trigger_q_reg   <= 1'b0;
            tx_word_reg     <= '0;
            busy_reg        <= 1'b0;
            image_end_reg   <= 1'b0;
            overrun_reg     <= 1'b0;
            frame_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            word_reg      <= word_next;
            line_reg      <= line_next;
            trigger_q_reg <= trigger;
            tx_word_reg   <= pack_txin(emit);
            image_end_reg <= end_next;
            if (go) begin
                pat_reg      <= cfg_test_pattern;
                h_words_reg  <= cfg_h_words;
                h_blank_reg  <= cfg_h_blank;
                v_lines_reg  <= cfg_v_lines;
                fv_setup_reg <= cfg_fv_setup;
                busy_reg     <= 1'b1;
            end else if (end_next) begin
                busy_reg <= 1'b0;
            end
            if (end_next)
                frame_count_reg <= frame_count_reg + CNT_W'(1);
            if (start && !idle_free)
                overrun_reg <= 1'b1;
        end
    end

    assign tx_word      = tx_word_reg;
    assign busy         = busy_reg;
    assign image_end    = image_end_reg;
    assign trig_overrun = overrun_reg;
    assign frame_count  = frame_count_reg;

endmodule

// File: tb/tb_clink_base_tx_framer.sv
// Directed bench for clink_base_tx_framer: runs short frames, captures tx_word per cycle and
// checks timing, packing, stream handshake, overrun and reset against hand-computed values.
module tb_clink_base_tx_framer;
    import clink_pkg::*;

    localparam int H_W   = 12;
    localparam int V_W   = 12;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             trigger = 1'b0;
    logic             cfg_test_pattern = 1'b0;
    logic [H_W-1:0]   cfg_h_words = '0;
    logic [H_W-1:0]   cfg_h_blank = '0;
    logic [V_W-1:0]   cfg_v_lines = '0;
    logic [7:0]       cfg_fv_setup = '0;
    logic [23:0]      s_pix_tdata = '0;
    logic             s_pix_tvalid = 1'b0;
    logic             s_pix_tready;
    logic [27:0]      tx_word;
    logic             busy;
    logic             image_end;
    logic             trig_overrun;
    logic [CNT_W-1:0] frame_count;

    always #5 clk = ~clk;

    clink_base_tx_framer #(.H_W(H_W), .V_W(V_W), .CNT_W(CNT_W)) dut (
        .clink_X_clk      (clk),
        .reset            (reset),
        .trigger          (trigger),
        .cfg_test_pattern (cfg_test_pattern),
        .cfg_h_words      (cfg_h_words),
        .cfg_h_blank      (cfg_h_blank),
        .cfg_v_lines      (cfg_v_lines),
        .cfg_fv_setup     (cfg_fv_setup),
        .s_pix_tdata      (s_pix_tdata),
        .s_pix_tvalid     (s_pix_tvalid),
        .s_pix_tready     (s_pix_tready),
        .tx_word          (tx_word),
        .busy             (busy),
        .image_end        (image_end),
        .trig_overrun     (trig_overrun),
        .frame_count      (frame_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [27:0] cw  [$];
    logic        ce  [$];
    logic        cb  [$];
    logic        ctr [$];
    logic [23:0] feed [$];
    int          feed_idx;
    bit          stall [256];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic set_cfg(input logic pat, input int hw, input int hb, input int vl, input int fs);
        cfg_test_pattern = pat;
        cfg_h_words      = H_W'(hw);
        cfg_h_blank      = H_W'(hb);
        cfg_v_lines      = V_W'(vl);
        cfg_fv_setup     = 8'(fs);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; trigger = 1'b0; s_pix_tvalid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One frame transaction: cw[c] is tx_word as seen at negedge c, trigger/reset driven for the following edge
    task automatic run(input string name, input int n, input int trig_len, input int trig2, input int rst_at);
        cw.delete(); ce.delete(); cb.delete(); ctr.delete();
        feed_idx = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            cw.push_back(tx_word);
            ce.push_back(image_end);
            cb.push_back(busy);
            trigger      = (c < trig_len) || (c == trig2);
            reset        = (c == rst_at);
            s_pix_tvalid = (feed_idx < feed.size()) && !stall[c];
            s_pix_tdata  = (feed_idx < feed.size()) ? feed[feed_idx] : 24'h0;
            #1;
            ctr.push_back(s_pix_tready);
            if (s_pix_tvalid && s_pix_tready) feed_idx++;
        end
        trigger = 1'b0; s_pix_tvalid = 1'b0; reset = 1'b0;
        $display("run %s: %0d cycles, fval=%0d lval_pulses=%0d image_end=%0d frame_count=%0d overrun=%0b",
                 name, n, count_bit(25), lval_pulses(), count_end(), frame_count, trig_overrun);
    endtask

    function automatic int count_bit(input int b);
        int k = 0;
        foreach (cw[i]) if (cw[i][b]) k++;
        return k;
    endfunction

    function automatic int count_end();
        int k = 0;
        foreach (ce[i]) if (ce[i]) k++;
        return k;
    endfunction

    function automatic int count_busy();
        int k = 0;
        foreach (cb[i]) if (cb[i]) k++;
        return k;
    endfunction

    function automatic int count_nonzero();
        int k = 0;
        foreach (cw[i]) if (cw[i] != 28'h0) k++;
        return k;
    endfunction

    function automatic int lval_pulses();
        int k = 0;
        logic prev = 1'b0;
        foreach (cw[i]) begin
            if (cw[i][24] && !prev) k++;
            prev = cw[i][24];
        end
        return k;
    endfunction

    function automatic int lval_len(input int p);
        int k = -1;
        int len = 0;
        logic prev = 1'b0;
        foreach (cw[i]) begin
            if (cw[i][24] && !prev) k++;
            if (cw[i][24] && k == p) len++;
            prev = cw[i][24];
        end
        return len;
    endfunction

    function automatic int dval_lval_diff();
        int k = 0;
        foreach (cw[i]) if (cw[i][24] != cw[i][26]) k++;
        return k;
    endfunction

    function automatic logic [27:0] dval_word(input int n);
        int k = 0;
        foreach (cw[i]) begin
            if (cw[i][26]) begin
                if (k == n) return cw[i];
                k++;
            end
        end
        return 28'hFFFFFFF;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clink_base_t u;
        logic [23:0] exp_px [4];
        logic [27:0] exp_tx [4];

        foreach (stall[i]) stall[i] = 1'b0;

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_tx_word",   32'(tx_word), 32'h0);
        check("rst_busy",      32'(busy), 32'h0);
        check("rst_image_end", 32'(image_end), 32'h0);
        check("rst_overrun",   32'(trig_overrun), 32'h0);
        check("rst_fcount",    32'(frame_count), 32'h0);
        check("rst_tready",    32'(s_pix_tready), 32'h0);

        // Test pattern frame 4 words x 3 lines, blank 2, setup 1
        set_cfg(1'b1, 4, 2, 3, 1);
        run("pattern", 40, 1, -1, -1);
        check("t1_pre_idle",     32'(cw[0]), 32'h0);
        check("t1_latency_fval", 32'(cw[1][25]), 32'h1);
        check("t1_busy_rise",    32'(cb[1]), 32'h1);
        check("t1_fval_cycles",  32'(count_bit(25)), 32'd18);
        check("t1_lval_pulses",  32'(lval_pulses()), 32'd3);
        check("t1_lval_len0",    32'(lval_len(0)), 32'd4);
        check("t1_lval_len1",    32'(lval_len(1)), 32'd4);
        check("t1_lval_len2",    32'(lval_len(2)), 32'd4);
        check("t1_dval_eq_lval", 32'(dval_lval_diff()), 32'd0);
        check("t1_l1w0_txin",    32'(dval_word(4)), 32'h7048101);
        check("t1_l2w3_txin",    32'(dval_word(11)), 32'h718920B);
        check("t1_spare_bit",    32'(count_bit(23)), 32'd0);
        check("t1_image_end_n",  32'(count_end()), 32'd1);
        check("t1_image_end_at", 32'(ce[19]), 32'h1);
        check("t1_end_fval_low", 32'(cw[19][25]), 32'h0);
        check("t1_busy_end",     32'(cb[19]), 32'h0);
        check("t1_frame_count",  32'(frame_count), 32'd1);
        check("t1_no_overrun",   32'(trig_overrun), 32'h0);

        // Stream packing, one word per line, no setup
        do_reset();
        exp_px = '{24'h000080, 24'h000040, 24'h004000, 24'h800000};
        exp_tx = '{28'h7000020, 28'hF000000, 28'h7000400, 28'h7020000};
        feed.delete();
        foreach (exp_px[i]) feed.push_back(exp_px[i]);
        set_cfg(1'b0, 1, 1, 4, 0);
        run("stream_pack", 20, 1, -1, -1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_txin%0d", i), 32'(dval_word(i)), 32'(exp_tx[i]));
            u = unpack_txin(dval_word(i));
            check($sformatf("t2_unpack%0d", i), 32'({u.d2, u.d1, u.d0}), 32'(exp_px[i]));
        end
        check("t2_first_word_latency", 32'(cw[1]), 32'h7000020);
        check("t2_spare_bit",   32'(count_bit(23)), 32'd0);
        check("t2_accepted",    32'(feed_idx), 32'd4);
        check("t2_frame_count", 32'(frame_count), 32'd1);

        // Stream with a 2-cycle tvalid gap after the second word
        do_reset();
        exp_px = '{24'h030201, 24'h060504, 24'h090807, 24'h0C0B0A};
        feed.delete();
        foreach (exp_px[i]) feed.push_back(exp_px[i]);
        stall[3] = 1'b1; stall[4] = 1'b1;
        set_cfg(1'b0, 4, 0, 1, 1);
        run("stream_stall", 20, 1, -1, -1);
        stall[3] = 1'b0; stall[4] = 1'b0;
        check("t3_lval_len",    32'(lval_len(0)), 32'd6);
        check("t3_dval_gap",    32'(dval_lval_diff()), 32'd2);
        check("t3_stall0",      32'(cw[4]), 32'h3000000);
        check("t3_stall1",      32'(cw[5]), 32'h3000000);
        for (int i = 0; i < 4; i++) begin
            u = unpack_txin(dval_word(i));
            check($sformatf("t3_order%0d", i), 32'({u.d2, u.d1, u.d0}), 32'(exp_px[i]));
        end
        check("t3_tready_pre",   32'(ctr[0]), 32'h0);
        check("t3_tready_stall", 32'(ctr[3]), 32'h1);
        check("t3_tready_done",  32'(ctr[7]), 32'h0);
        check("t3_accepted",     32'(feed_idx), 32'd4);

        // Second trigger edge mid-frame
        do_reset();
        feed.delete();
        set_cfg(1'b1, 2, 1, 2, 1);
        run("overrun_mid", 30, 1, 3, -1);
        check("t4_image_end_n",  32'(count_end()), 32'd1);
        check("t4_fval_cycles",  32'(count_bit(25)), 32'd7);
        check("t4_overrun",      32'(trig_overrun), 32'h1);
        check("t4_frame_count",  32'(frame_count), 32'd1);

        // Trigger held high for 20 cycles
        do_reset();
        run("held_trigger", 40, 20, -1, -1);
        check("t4_held_frames",  32'(count_end()), 32'd1);
        check("t4_held_fval",    32'(count_bit(25)), 32'd7);
        check("t4_held_overrun", 32'(trig_overrun), 32'h0);
        check("t4_held_fcount",  32'(frame_count), 32'd1);

        // Edge on the image_end cycle is still an overrun
        do_reset();
        run("edge_on_end", 30, 1, 8, -1);
        check("t4_end_edge_ie",   32'(ce[8]), 32'h1);
        check("t4_end_edge_n",    32'(count_end()), 32'd1);
        check("t4_end_edge_ovr",  32'(trig_overrun), 32'h1);

        // Edge one cycle after image_end starts a new frame
        do_reset();
        run("edge_after_end", 30, 1, 9, -1);
        check("t4_after_end_n",   32'(count_end()), 32'd2);
        check("t4_after_end_ovr", 32'(trig_overrun), 32'h0);
        check("t4_after_end_fc",  32'(frame_count), 32'd2);

        // Reset during ACTIVE
        do_reset();
        set_cfg(1'b1, 4, 2, 3, 1);
        run("reset_mid", 40, 1, -1, 5);
        check("t5_was_active",   32'(cw[5][24]), 32'h1);
        check("t5_tx_cleared",   32'(cw[6]), 32'h0);
        check("t5_busy_cleared", 32'(cb[6]), 32'h0);
        check("t5_no_image_end", 32'(count_end()), 32'd0);
        check("t5_fcount_zero",  32'(frame_count), 32'd0);
        run("after_reset", 40, 1, -1, -1);
        check("t5_clean_fval",   32'(count_bit(25)), 32'd18);
        check("t5_clean_end",    32'(count_end()), 32'd1);
        check("t5_clean_fcount", 32'(frame_count), 32'd1);

        // Degenerate configuration is ignored
        do_reset();
        set_cfg(1'b1, 4, 2, 0, 1);
        run("zero_lines", 12, 1, -1, -1);
        check("t6_vl0_tx",      32'(count_nonzero()), 32'd0);
        check("t6_vl0_busy",    32'(count_busy()), 32'd0);
        check("t6_vl0_overrun", 32'(trig_overrun), 32'h0);
        set_cfg(1'b0, 0, 2, 3, 1);
        run("zero_words", 12, 1, -1, -1);
        check("t6_hw0_tx",      32'(count_nonzero()), 32'd0);
        check("t6_hw0_busy",    32'(count_busy()), 32'd0);
        check("t6_hw0_overrun", 32'(trig_overrun), 32'h0);
        check("t6_hw0_tready",  32'(ctr[0]), 32'h0);
        check("t6_fcount",      32'(frame_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
